// File: rtl/rv_mem_bridge.sv
// ---------------------------------------------------------------------------
// rv_mem_bridge
//
// Purpose:
//   Turns the core's single-cycle memory strobes into a request/acknowledge
//   transaction on a variable-latency word memory. The core is frozen with
//   `stall` until the access completes. Misaligned addresses are rejected
//   without touching memory. Accesses that wait too long are abandoned with
//   an error. Errored accesses are counted in a saturating counter.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   req_valid/we/addr/wdata
//                     core request, held until the rsp_valid cycle
//   stall             core must hold its state while high
//   rsp_valid         one-cycle completion pulse
//   rsp_rdata         read data, held until the next completion
//   rsp_err           error flag, held until the next completion
//   mem_req/we/addr/wdata
//                     memory request side (mem_addr is word aligned)
//   mem_ack           single-cycle memory completion
//   mem_rdata         read data, valid together with mem_ack on reads
//   err_cnt           saturating count of errored accesses
// ---------------------------------------------------------------------------
module rv_mem_bridge #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int TIMEOUT  = 16,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                stall,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [ERRCNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // TIMEOUT never exceeds 255, so an 8-bit wait counter always suffices.
   localparam logic [7:0]          WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [ERRCNT_W-1:0] ERR_ONE   = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [7:0]          wait_q, wait_d;
   logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
   logic                err_inc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wait_q   <= '0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         wait_q   <= wait_d;
         errcnt_q <= errcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wait_d  = wait_q;
      err_inc = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_addr[1:0] == 2'b00) begin
                  addr_d  = req_addr;
                  we_d    = req_we;
                  wdata_d = req_wdata;
                  wait_d  = '0;
                  state_d = ACCESS;
               end else begin
                  // Rejected without a memory cycle; read data is left alone.
                  err_d   = 1'b1;
                  err_inc = 1'b1;
                  state_d = DONE;
               end
            end
         end
         ACCESS: begin
            wait_d = wait_q + 8'd1;
            // An ack on the final wait cycle still counts as success.
            if (mem_ack) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               err_d   = 1'b0;
               state_d = DONE;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               err_inc = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      errcnt_d = errcnt_q;
      if (err_inc && (errcnt_q != {ERRCNT_W{1'b1}})) begin
         errcnt_d = errcnt_q + ERR_ONE;
      end
   end

   // In IDLE the core is frozen as soon as it raises a request so that it
   // does not advance before the bridge has registered it.
   assign stall     = (state_q == IDLE) ? req_valid : (state_q == ACCESS);
   assign rsp_valid = (state_q == DONE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_req   = (state_q == ACCESS);
   assign mem_we    = (state_q == ACCESS) && we_q;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = wdata_q;
   assign err_cnt   = errcnt_q;

endmodule

// File: tb/tb_rv_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv_mem_bridge
//
// Self-checking bench for rv_mem_bridge: a table of directed accesses with
// hand-derived expectations, hand-written reset/saturation sequences, and a
// randomized run checked against a word-memory reference model.
// ---------------------------------------------------------------------------
module tb_rv_mem_bridge;

   localparam int TIMEOUT = 16;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   rv_mem_bridge #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .ERRCNT_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends just after a rising edge. Holds the request until the
   // rsp_valid cycle; the memory acks on ACCESS cycle number `delay`
   // (0 = first); a delay of TIMEOUT or more means no ack at all.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int delay, input logic [31:0] rdval,
                            output int lat, output int reqc, output bit bus_ok, output bit stall_ok);
      int cyc;
      bit done;
      cyc = 0; done = 0; lat = -1; reqc = 0; bus_ok = 1; stall_ok = 1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      while (!done && cyc < 64) begin
         if (mem_req === 1'b1) begin
            if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== we || (we && mem_wdata !== wdata))
               bus_ok = 0;
            mem_ack   = (reqc == delay);
            mem_rdata = (reqc == delay) ? rdval : $urandom();
            reqc++;
         end else begin
            if (mem_we !== 1'b0) bus_ok = 0;
            mem_ack   = 1'b0;
            mem_rdata = $urandom();
         end
         #1;
         if (rsp_valid === 1'b1) begin
            done = 1;
            lat  = cyc;
            if (stall !== 1'b0) stall_ok = 0;
         end else if (stall !== 1'b1) begin
            stall_ok = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      req_valid = 1'b0;
      mem_ack   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_valid = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdval;
      int          exp_lat;
      int          exp_reqc;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_errcnt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, reqc, pulses, bad_timing, req_seen;
      bit bus_ok, stall_ok;
      logic [31:0] model_mem[16];
      logic [31:0] exp_rdata;
      int errs;

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;

      //           we    addr          wdata         dly rdval         lat reqc err rdata        errcnt
      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,        0,  32'hDEAD_BEEF, 2,  1,  1'b0, 32'hDEAD_BEEF, 0};
      vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 3, 32'h5555_AAAA, 5,  4,  1'b0, 32'hDEAD_BEEF, 0};
      vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,        0,  32'h1111_1111, 1,  0,  1'b1, 32'hDEAD_BEEF, 1};
      vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,        99, 32'h2222_2222, 17, 16, 1'b1, 32'h0,         2};
      vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,        15, 32'hCAFE_F00D, 17, 16, 1'b0, 32'hCAFE_F00D, 2};
      vecs[5] = '{1'b1, 32'h0000_000A, 32'h7777_7777, 0, 32'h3333_3333, 1,  0,  1'b1, 32'hCAFE_F00D, 3};
      vecs[6] = '{1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 0, 32'h4444_4444, 2,  1,  1'b0, 32'hCAFE_F00D, 3};
      vecs[7] = '{1'b0, 32'h0000_0030, 32'h0,        1,  32'h0BAD_C0DE, 3,  2,  1'b0, 32'h0BAD_C0DE, 3};

      do_reset();
      #1;
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("reset mem_req", {31'b0, mem_req}, 32'd0);
      check("reset mem_we", {31'b0, mem_we}, 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'd0);
      check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
      check("reset err_cnt", {24'b0, err_cnt}, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay, vecs[i].rdval,
                   lat, reqc, bus_ok, stall_ok);
         $display("vec %0d: we=%0d addr=%h lat=%0d req_cycles=%0d err=%0d rdata=%h err_cnt=%0d",
                  i, vecs[i].we, vecs[i].addr, lat, reqc, rsp_err, rsp_rdata, err_cnt);
         check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d mem_req cycles", i), reqc, vecs[i].exp_reqc);
         check($sformatf("vec%0d rsp_err", i), {31'b0, rsp_err}, {31'b0, vecs[i].exp_err});
         check($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d err_cnt", i), {24'b0, err_cnt}, vecs[i].exp_errcnt);
         check($sformatf("vec%0d bus", i), {31'b0, bus_ok}, 32'd1);
         check($sformatf("vec%0d stall", i), {31'b0, stall_ok}, 32'd1);
      end

      // Reset on the second ACCESS cycle abandons the access.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0050;
      @(posedge clk); #1;
      check("midrst mem_req before", {31'b0, mem_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst mem_req", {31'b0, mem_req}, 32'd0);
      check("midrst stall", {31'b0, stall}, 32'd0);
      check("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("midrst err_cnt", {24'b0, err_cnt}, 32'd0);
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid === 1'b1 || mem_req === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      $display("midrst: stray ack, activity cycles=%0d", pulses);
      check("midrst stray ack", pulses, 0);
      check("midrst rsp_rdata", rsp_rdata, 32'd0);

      // 300 back-to-back misaligned requests with req_valid held.
      do_reset();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0013;
      pulses = 0; bad_timing = 0; req_seen = 0;
      for (int c = 0; c < 600; c++) begin
         if (rsp_valid === 1'b1) pulses++;
         if (rsp_valid !== ((c % 2) == 1)) bad_timing++;
         if (mem_req !== 1'b0) req_seen++;
         if (c == 200) check("b2b err_cnt at 100", {24'b0, err_cnt}, 32'd100);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      $display("b2b: pulses=%0d bad_timing=%0d mem_req_cycles=%0d err_cnt=%0d",
               pulses, bad_timing, req_seen, err_cnt);
      check("b2b pulses", pulses, 300);
      check("b2b timing", bad_timing, 0);
      check("b2b mem_req", req_seen, 0);
      check("b2b err_cnt sat", {24'b0, err_cnt}, 32'd255);
      do_access(1'b1, 32'h0000_0041, 32'h0, 0, 32'h0, lat, reqc, bus_ok, stall_ok);
      check("sat stays", {24'b0, err_cnt}, 32'd255);

      // Randomized accesses against a word-memory model.
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) model_mem[i] = $urandom();
      exp_rdata = '0;
      errs = 0;
      for (int t = 0; t < 40; t++) begin
         logic        we, misal, tout;
         logic [31:0] addr, wdata;
         int          delay, idx, e_lat, e_reqc;
         we    = 1'($urandom_range(0, 1));
         addr  = $urandom();
         addr[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         wdata = $urandom();
         delay = $urandom_range(0, 20);
         idx   = int'(addr[5:2]);
         misal = (addr[1:0] != 2'b00);
         tout  = !misal && (delay >= TIMEOUT);
         do_access(we, addr, wdata, delay, model_mem[idx], lat, reqc, bus_ok, stall_ok);
         if (misal) begin
            e_lat = 1; e_reqc = 0; errs++;
         end else if (tout) begin
            e_lat = TIMEOUT + 1; e_reqc = TIMEOUT; errs++; exp_rdata = '0;
         end else begin
            e_lat = delay + 2; e_reqc = delay + 1;
            if (we) model_mem[idx] = wdata;
            else    exp_rdata = model_mem[idx];
         end
         $display("rnd %0d: we=%0d addr=%h delay=%0d lat=%0d err=%0d rdata=%h err_cnt=%0d",
                  t, we, addr, delay, lat, rsp_err, rsp_rdata, err_cnt);
         check($sformatf("rnd%0d latency", t), lat, e_lat);
         check($sformatf("rnd%0d mem_req cycles", t), reqc, e_reqc);
         check($sformatf("rnd%0d rsp_err", t), {31'b0, rsp_err}, {31'b0, misal | tout});
         check($sformatf("rnd%0d rsp_rdata", t), rsp_rdata, exp_rdata);
         check($sformatf("rnd%0d err_cnt", t), {24'b0, err_cnt}, (errs > 255) ? 255 : errs);
         check($sformatf("rnd%0d bus", t), {31'b0, bus_ok}, 32'd1);
         check($sformatf("rnd%0d stall", t), {31'b0, stall_ok}, 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv_mem_bridge.md
Name: rv_mem_bridge

Overview:
- Memory-side neighbour of the multicycle control/datapath pair. Converts the core's single-cycle memory strobes (instruction fetch, load, store) into a request/acknowledge transaction on a variable-latency word memory.
- Holds the core in place with `stall` until the access completes.
- Enforces word alignment and a bounded wait (timeout).
- Reports errors per access and keeps a saturating error count.

Parameters:
- ADDR_W, 32, address width of core and memory ports.
- DATA_W, 32, data width.
- TIMEOUT, 16, max ACCESS cycles waiting for mem_ack; legal range 2..255.
- ERRCNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets).
- req_valid  in  1  core requests an access; held until the rsp_valid cycle.
- req_we  in  1  1=store, 0=load/fetch.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- stall  out  1  core must freeze its state machine while 1.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; held stable until the next completion.
- rsp_err  out  1  error flag for the completing access; valid with rsp_valid, held until the next completion.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion, single cycle.
- mem_rdata  in  DATA_W  valid when mem_ack==1 and mem_we==0.
- err_cnt  out  ERRCNT_W  saturating count of errored accesses.

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE.
  - Latched addr/we/wdata, rsp_rdata, rsp_err, wait counter and err_cnt all reset to 0.
  - rsp_valid=0, mem_req=0, stall=0.
  - Reset during ACCESS: mem_req deasserts after that edge and the transaction is abandoned; a late mem_ack is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - stall = req_valid (combinational); mem_req=0.
  - On req_valid with req_addr[1:0]==0: latch req_addr, req_we, req_wdata; clear wait counter; next=ACCESS.
  - On req_valid with req_addr[1:0]!=0: no memory access; rsp_err<=1; rsp_rdata unchanged; err_cnt increments; next=DONE.
- ACCESS:
  - stall=1; mem_req=1.
  - mem_addr/mem_we/mem_wdata driven from latched registers, constant for the whole state.
  - Wait counter increments each cycle.
  - mem_ack==1: if read, rsp_rdata<=mem_rdata; rsp_err<=0; next=DONE.
  - No ack and counter==TIMEOUT-1 (the TIMEOUT-th ACCESS cycle): rsp_err<=1, rsp_rdata<=0, err_cnt increments, next=DONE.
  - mem_ack on the timeout cycle: ack wins, no error.
- DONE:
  - rsp_valid=1, stall=0, mem_req=0; next=IDLE unconditionally.
  - req_valid is ignored in DONE; a back-to-back request is accepted in the following IDLE cycle.
- Outputs outside ACCESS: mem_ack ignored; mem_we=0; mem_addr/mem_wdata hold their last latched values.
- Stores: rsp_rdata unchanged on completion.
- err_cnt saturates at all-ones and does not wrap.
- Latency: with ack on the first ACCESS cycle, the request is seen in cycle 0 (IDLE), mem_req is high in cycle 1, and rsp_valid is high in cycle 2. Each extra memory wait cycle adds 1.
- Misaligned access: rsp_valid one cycle after the request, with no mem_req.
- Max aligned latency: TIMEOUT+1 cycles from request to rsp_valid.

Test Plan:
1. Aligned load, addr=0x0000_0010, mem_ack in first ACCESS cycle with mem_rdata=0xDEAD_BEEF -> mem_req high exactly 1 cycle with mem_addr=0x10, mem_we=0; rsp_valid at cycle 2; rsp_rdata=0xDEAD_BEEF; rsp_err=0; stall high cycles 0-1.
2. Store, addr=0x20, wdata=0x1234_5678, ack after 3 wait cycles -> mem_we=1 and mem_wdata=0x1234_5678 for 4 cycles; rsp_valid at cycle 5; rsp_rdata unchanged.
3. Misaligned load, addr=0x0000_0013 -> mem_req never asserted; rsp_valid at cycle 1 with rsp_err=1; err_cnt 0->1.
4. No ack, TIMEOUT=16 -> mem_req high exactly 16 cycles; rsp_valid at cycle 17 with rsp_err=1, rsp_rdata=0; then ack arrives on the 16th ACCESS cycle in a rerun -> rsp_err=0, data captured.
5. Reset mid-access: rst=0 on the 2nd ACCESS cycle -> next cycle mem_req=0, stall=0, rsp_valid=0, err_cnt=0; a stray mem_ack afterwards produces no rsp_valid.
6. 300 misaligned requests back-to-back (req_valid held) -> a new access is accepted every 2 cycles; err_cnt saturates at 255 and stays there.
